ps2_dir_decoder: RTL



---
 rtl/ps2_dir_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 receiver and arrow-key direction/step decoder
module ps2_dir_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int STEP_PERIOD    = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       step,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STEP_PERIOD + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  rx_state_t              rx_state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_bit;
  logic [TW-1:0]          tcnt;

  logic                   stop_ok;
  logic                   stop_bad;
  logic                   timeout_hit;
  logic                   rx_err;

  logic [3:0]             key_sel;
  logic [3:0]             levels;
  logic                   brk_flag;

  logic                   any_held;
  logic                   any_prev;
  logic [SW-1:0]          scnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Synchronize both PS/2 lines; reset to the idle-high level so no false edge follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Frame-completion and error conditions evaluated on the detecting cycle
  always_comb begin
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    timeout_hit = 1'b0;
    if (fall && rx_state == STOP) begin
      stop_ok  = data_s & (^{shift, par_bit});
      stop_bad = ~stop_ok;
    end
    if (rx_state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1))
      timeout_hit = 1'b1;
    rx_err = stop_bad | timeout_hit;
  end

  // Receiver FSM: start, 8 data bits LSB first, odd parity, stop; timeout aborts mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      scan_valid <= stop_ok;
      frame_err  <= rx_err;
      if (stop_ok)
        scan_code <= shift;

      if (rx_state == IDLE || fall)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      if (timeout_hit) begin
        rx_state <= IDLE;
      end else if (fall) begin
        case (rx_state)
          IDLE: begin
            if (!data_s) begin
              rx_state <= DATA;
              bit_cnt  <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              rx_state <= PARITY;
          end
          PARITY: begin
            par_bit  <= data_s;
            rx_state <= STOP;
          end
          STOP: rx_state <= IDLE;
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

  // Arrow key codes; arrow and keypad forms share the same code, so the E0 prefix never changes the mapping
  always_comb begin
    key_sel = 4'b0000;
    case (shift)
      8'h6B:   key_sel = 4'b1000;
      8'h74:   key_sel = 4'b0100;
      8'h75:   key_sel = 4'b0010;
      8'h72:   key_sel = 4'b0001;
      default: key_sel = 4'b0000;
    endcase
  end

  // Make/break decoding; E0 is consumed as a prefix with no further effect, errors drop a pending break
  always_ff @(posedge clk) begin
    if (reset) begin
      levels   <= 4'b0000;
      brk_flag <= 1'b0;
    end else if (stop_ok) begin
      if (shift == 8'hF0) begin
        brk_flag <= 1'b1;
      end else if (shift != 8'hE0) begin
        if (brk_flag)
          levels <= levels & ~key_sel;
        else
          levels <= levels | key_sel;
        brk_flag <= 1'b0;
      end
    end else if (rx_err) begin
      brk_flag <= 1'b0;
    end
  end

  assign left     = levels[3];
  assign right    = levels[2];
  assign up       = levels[1];
  assign down     = levels[0];
  assign any_held = |levels;

  // Step pulse on first press, then every STEP_PERIOD cycles while anything stays held
  always_ff @(posedge clk) begin
    if (reset) begin
      any_prev <= 1'b0;
      scnt     <= '0;
      step     <= 1'b0;
    end else begin
      any_prev <= any_held;
      if (!any_held) begin
        scnt <= '0;
        step <= 1'b0;
      end else if (!any_prev) begin
        scnt <= '0;
        step <= 1'b1;
      end else if (scnt == SW'(STEP_PERIOD - 1)) begin
        scnt <= '0;
        step <= 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
        step <= 1'b0;
      end
    end
  end

endmodule
